// File: rtl/mmio_pkg.sv
// Shared memory-map constants and RX status bit positions for the MMIO memory.
// Pure constants: no logic, no latency, no flow control.
package mmio_pkg;
    localparam int OUT_TOP   = 127;
    localparam int IN_TOP    = 125;
    localparam int UART_DATA = 122;
    localparam int UART_STAT = 121;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_CNT_LSB   = 8;
endpackage

// File: rtl/mmio_rx_fifo.sv
// UART RX byte FIFO: head visible combinationally, push/pop take effect at posedge.
// A push into a full FIFO with no pop that cycle is dropped and sets the sticky overflow.
module mmio_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_dat,
    input  logic                     pop,
    input  logic                     clr_ovf,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = store[rd_ptr];
    // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !do_push)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            store[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/mmio_memory.sv
// Unified instruction/data RAM with an MMIO window (output/input ports, UART RX FIFO); reads are combinational, writes land at posedge.
// RX bytes arriving while the FIFO is full are dropped; MMIO_WRITE_PROTECT_EN blocks writes at or below PROT_LIMIT.
module mmio_memory
    import mmio_pkg::*;
#(
    parameter int WORD_SIZE      = 16,
    parameter int MEMORY_SIZE    = 128,
    parameter int NUM_OUT        = 2,
    parameter int NUM_IN         = 1,
    parameter int OUT_TOP_ADDR   = OUT_TOP,
    parameter int IN_TOP_ADDR    = IN_TOP,
    parameter int UART_DATA_ADDR = UART_DATA,
    parameter int UART_STAT_ADDR = UART_STAT,
    parameter int FIFO_DEPTH     = 4,
    parameter int PROT_LIMIT     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_SIZE-1:0]          addr,
    input  logic [WORD_SIZE-1:0]          data_in,
    input  logic                          write,
    input  logic                          read,
    output logic [WORD_SIZE-1:0]          data_out,
    output logic [NUM_OUT*WORD_SIZE-1:0]  out_ports,
    input  logic [NUM_IN*WORD_SIZE-1:0]   in_ports,
    input  logic [7:0]                    in_uart,
    input  logic                          uart_new_data,
    output logic                          prot_fault
);
    localparam int AW = $clog2(MEMORY_SIZE);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_SIZE-1:0] mem    [MEMORY_SIZE];
    logic [WORD_SIZE-1:0] out_q  [NUM_OUT];
    logic [WORD_SIZE-1:0] in_q   [NUM_IN];
    logic                 uart_prev;
    logic                 in_range, is_data, is_stat, io_hit;
    logic                 prot_block, wr_ok;
    logic [7:0]           fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty, fifo_ovf;
    logic [WORD_SIZE-1:0] status;

    assign in_range = (addr < WORD_SIZE'(MEMORY_SIZE));
    assign is_data  = (addr == WORD_SIZE'(UART_DATA_ADDR));
    assign is_stat  = (addr == WORD_SIZE'(UART_STAT_ADDR));
    assign wr_ok    = write && !rst && in_range && !prot_block;

`ifdef MMIO_WRITE_PROTECT_EN
    assign prot_block = (addr <= WORD_SIZE'(PROT_LIMIT));

    always_ff @(posedge clk) begin
        if (rst)
            prot_fault <= 1'b0;
        else if (write && prot_block)
            prot_fault <= 1'b1;
    end
`else
    logic unused_prot_limit;
    assign unused_prot_limit = (addr <= WORD_SIZE'(PROT_LIMIT));
    assign prot_block        = 1'b0;
    assign prot_fault        = 1'b0;
`endif

    always_comb begin
        status                       = '0;
        status[ST_NOT_EMPTY]         = !fifo_empty;
        status[ST_FULL]              = fifo_full;
        status[ST_OVF]               = fifo_ovf;
        status[ST_CNT_LSB +: CW]     = fifo_count;
    end

    // Read mux; io_hit also keeps mapped addresses out of the RAM write path.
    always_comb begin
        io_hit   = is_data || is_stat;
        data_out = '0;
        if (in_range)
            data_out = mem[addr[AW-1:0]];
        for (int i = 0; i < NUM_OUT; i++) begin
            if (addr == WORD_SIZE'(OUT_TOP_ADDR - i)) begin
                io_hit   = 1'b1;
                data_out = out_q[i];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (addr == WORD_SIZE'(IN_TOP_ADDR - i)) begin
                io_hit   = 1'b1;
                data_out = in_q[i];
            end
        end
        if (is_stat)
            data_out = status;
        if (is_data)
            data_out = fifo_empty ? '0 : WORD_SIZE'(fifo_head);
    end

    // RAM is never reset so the program image survives rst.
    always_ff @(posedge clk) begin
        if (wr_ok && !io_hit)
            mem[addr[AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++)
                out_q[i] <= '0;
            for (int i = 0; i < NUM_IN; i++)
                in_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (wr_ok && addr == WORD_SIZE'(OUT_TOP_ADDR - i))
                    out_q[i] <= data_in;
            end
            for (int i = 0; i < NUM_IN; i++)
                in_q[i] <= in_ports[i*WORD_SIZE +: WORD_SIZE];
        end
        uart_prev <= uart_new_data;
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_ports[g*WORD_SIZE +: WORD_SIZE] = out_q[g];
    end

    mmio_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (uart_new_data && !uart_prev),
        .push_dat (in_uart),
        .pop      (read && is_data),
        .clr_ovf  (wr_ok && is_stat),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );
endmodule

// File: tb/tb_mmio_memory.sv
// Directed scenarios plus randomized traffic for mmio_memory, checked against a queue/array model.
module tb_mmio_memory;
`ifdef MMIO_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, write, read, uart_new_data, prot_fault;
    logic [15:0] addr, data_in, data_out, in_ports;
    logic [31:0] out_ports;
    logic [7:0]  in_uart;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_memory dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .data_in       (data_in),
        .write         (write),
        .read          (read),
        .data_out      (data_out),
        .out_ports     (out_ports),
        .in_ports      (in_ports),
        .in_uart       (in_uart),
        .uart_new_data (uart_new_data),
        .prot_fault    (prot_fault)
    );

    // Reference model state
    logic [15:0] m_mem [128];
    bit          m_known [128];
    logic [15:0] m_out [2];
    logic [15:0] m_in;
    logic [7:0]  m_q [$];
    bit          m_ovf, m_pf, m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a >= 16'd128) return 16'h0000;
        case (a)
            16'd127: return m_out[0];
            16'd126: return m_out[1];
            16'd125: return m_in;
            16'd122: return (m_q.size() != 0) ? {8'h00, m_q[0]} : 16'h0000;
            16'd121: return {8'(m_q.size()), 5'b0, m_ovf, m_q.size() == 4, m_q.size() != 0};
            default: return m_mem[a[6:0]];
        endcase
    endfunction

    function automatic bit m_known_addr(input logic [15:0] a);
        if (a >= 16'd128) return 1'b1;
        if (a inside {16'd127, 16'd126, 16'd125, 16'd122, 16'd121}) return 1'b1;
        return m_known[a[6:0]];
    endfunction

    // Advance the model by one clock using the inputs currently applied, then step the DUT.
    task automatic tick();
        bit pop, push;
        pop  = read && addr == 16'd122 && m_q.size() != 0;
        push = uart_new_data && !m_prev;
        if (rst) begin
            m_out[0] = '0; m_out[1] = '0; m_in = '0;
            m_q.delete(); m_ovf = 1'b0; m_pf = 1'b0;
        end else begin
            if (write) begin
                if (PROT && addr <= 16'd32)
                    m_pf = 1'b1;
                else if (addr < 16'd128) begin
                    if (addr == 16'd127) m_out[0] = data_in;
                    else if (addr == 16'd126) m_out[1] = data_in;
                    else if (addr == 16'd121) m_ovf = 1'b0;
                    else if (!(addr inside {16'd125, 16'd122})) begin
                        m_mem[addr[6:0]]   = data_in;
                        m_known[addr[6:0]] = 1'b1;
                    end
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < 4) m_q.push_back(in_uart);
                else m_ovf = 1'b1;
            end
            m_in = in_ports;
        end
        m_prev = uart_new_data;
        @(posedge clk);
        #1;
    endtask

    task automatic set(input bit r, input logic [15:0] a, input logic [15:0] d, input bit w, input bit rd);
        rst = r; addr = a; data_in = d; write = w; read = rd;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_uart = b; uart_new_data = 1'b1;
        tick();
        uart_new_data = 1'b0;
        tick();
    endtask

    task automatic check_model(input string tag);
        if (m_known_addr(addr))
            check({tag, ":data"}, {16'h0, data_out}, {16'h0, m_read(addr)});
        check({tag, ":out"}, out_ports, {m_out[1], m_out[0]});
        check({tag, ":fault"}, {31'h0, prot_fault}, {31'h0, m_pf});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_bytes [4];
        m_out[0] = '0; m_out[1] = '0; m_in = '0;
        m_ovf = 1'b0; m_pf = 1'b0; m_prev = 1'b0;
        for (int i = 0; i < 128; i++) m_known[i] = 1'b0;
        in_ports = '0; in_uart = '0; uart_new_data = 1'b0;
        set(1, 0, 0, 0, 0);
        #1;
        tick(); tick();

        // Reset state
        set(0, 16'd121, 0, 0, 0);
        #2;
        check("reset_out", out_ports, 32'h0);
        check("reset_fault", {31'h0, prot_fault}, 32'h0);
        check("reset_stat", {16'h0, data_out}, 32'h0);

        // Output ports and RAM survival across reset
        set(0, 16'd40, 16'hA5A5, 1, 0); tick();
        set(0, 16'd127, 16'h1234, 1, 0); tick();
        #2 check("out0_next_cycle", {16'h0, out_ports[15:0]}, 32'h1234);
        set(0, 16'd126, 16'h00FF, 1, 0); tick();
        set(0, 16'd40, 0, 0, 0);
        #2;
        check("out_both", out_ports, 32'h00FF_1234);
        check("ram40", {16'h0, data_out}, 32'hA5A5);
        set(1, 16'd40, 0, 0, 0); tick();
        set(0, 16'd40, 0, 0, 0);
        #2;
        check("rst_clears_out", out_ports, 32'h0);
        check("ram40_kept", {16'h0, data_out}, 32'hA5A5);

        // Input port register lag and write immunity
        in_ports = 16'h0005;
        set(0, 16'd125, 0, 0, 0);
        #2 check("in_lag", {16'h0, data_out}, 32'h0);
        tick();
        #2 check("in_registered", {16'h0, data_out}, 32'h5);
        set(0, 16'd125, 16'h9999, 1, 0); tick();
        set(0, 16'd125, 0, 0, 0);
        #2 check("in_write_ignored", {16'h0, data_out}, 32'h5);

        // FIFO push and pop order
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        set(0, 16'd121, 0, 0, 0);
        #2 check("stat_three", {16'h0, data_out}, 32'h0301);
        set(0, 16'd122, 0, 0, 1);
        #2 check("pop_41", {16'h0, data_out}, 32'h41);
        tick();
        #2 check("pop_42", {16'h0, data_out}, 32'h42);
        tick();
        #2 check("pop_43", {16'h0, data_out}, 32'h43);
        tick();
        set(0, 16'd122, 0, 0, 0);
        #2 check("data_empty", {16'h0, data_out}, 32'h0);
        addr = 16'd121;
        #1 check("stat_empty", {16'h0, data_out}, 32'h0);

        // Overflow on the fifth byte, then clear via status write
        for (int b = 8'h50; b <= 8'h54; b++) push_byte(8'(b));
        set(0, 16'd121, 0, 0, 0);
        #2 check("stat_overflow", {16'h0, data_out}, 32'h0407);
        set(0, 16'd121, 0, 1, 0); tick();
        set(0, 16'd121, 0, 0, 0);
        #2 check("stat_ovf_cleared", {16'h0, data_out}, 32'h0403);

        // Full FIFO: push and pop in the same cycle
        set(0, 16'd122, 0, 0, 1);
        in_uart = 8'h60; uart_new_data = 1'b1;
        #2 check("fullpop_head", {16'h0, data_out}, 32'h50);
        tick();
        uart_new_data = 1'b0;
        set(0, 16'd121, 0, 0, 0);
        #2 check("fullpop_stat", {16'h0, data_out}, 32'h0403);
        exp_bytes[0] = 8'h51; exp_bytes[1] = 8'h52; exp_bytes[2] = 8'h53; exp_bytes[3] = 8'h60;
        set(0, 16'd122, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #2 check($sformatf("drain_%0d", i), {16'h0, data_out}, {24'h0, exp_bytes[i]});
            tick();
        end
        set(0, 16'd122, 0, 0, 0);
        #2 check_model("after_drain");

        // Write protection and out-of-range addresses
        set(0, 16'd10, 16'hBEEF, 1, 0); tick();
        set(0, 16'd10, 0, 0, 0);
        #2;
`ifdef MMIO_WRITE_PROTECT_EN
        check("prot_fault_set", {31'h0, prot_fault}, 32'h1);
        check("prot_blocked", {31'h0, data_out !== 16'hBEEF}, 32'h1);
`else
        check("ram10_written", {16'h0, data_out}, 32'hBEEF);
        check("no_prot_fault", {31'h0, prot_fault}, 32'h0);
`endif
        set(0, 16'd33, 16'h3333, 1, 0); tick();
        set(0, 16'd72, 16'h7272, 1, 0); tick();
        set(0, 16'd200, 16'hDEAD, 1, 0); tick();
        set(0, 16'd33, 0, 0, 0);
        #2 check("ram33", {16'h0, data_out}, 32'h3333);
        addr = 16'd200;
        #1 check("addr200_reads0", {16'h0, data_out}, 32'h0);
        addr = 16'd72;
        #1 check("addr200_no_alias", {16'h0, data_out}, 32'h7272);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 9))
                0:       a = 16'd127;
                1:       a = 16'd126;
                2:       a = 16'd125;
                3:       a = 16'd122;
                4:       a = 16'd121;
                5:       a = 16'($urandom_range(33, 120));
                6:       a = 16'($urandom_range(0, 32));
                7:       a = 16'($urandom_range(128, 65535));
                default: a = 16'($urandom_range(0, 127));
            endcase
            set($urandom_range(0, 199) == 0, a, 16'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1);
            in_uart       = 8'($urandom);
            uart_new_data = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) in_ports = 16'($urandom);
            #2 check_model($sformatf("rand_%0d", n));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
